// File: rtl/ssd1306_microcode_sequencer.sv
// Microcode walker for SSD1306 panel bring-up: fetches 10-bit words from an external ROM
// and turns each into a command byte, data byte, programmed delay, or end of sequence.
//
// state  | meaning
// IDLE   | waiting for start, busy low
// FETCH  | decode rom_data at rom_address
// SEND   | tx_valid held until serializer handshake
// DELAY  | counting down arg*DELAY_UNIT cycles
// FINISH | one-cycle done pulse, address rewound
module ssd1306_microcode_sequencer #(
  parameter int SIZE       = 40,
  parameter int DATA_WIDTH = 10,
  parameter int DELAY_UNIT = 1000,
  localparam int ADDR_BITS = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  rom_overflow,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_byte,
  output logic                  tx_dc
);

  localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
  localparam logic [CNT_W-1:0] DU_C = CNT_W'(DELAY_UNIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND   = 3'd2,
    DELAY  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [1:0] OP_DLY = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_dc_q, tx_dc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 advance;

  logic [1:0] opcode;
  logic [7:0] arg;

  assign opcode = rom_data[9:8];
  assign arg    = rom_data[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_dc_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      tx_dc_q    <= tx_dc_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    tx_dc_d    = tx_dc_q;
    cnt_d      = cnt_q;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (rom_overflow || opcode == OP_END) begin
          state_d = FINISH;
        end else if (opcode != OP_DLY) begin
          tx_byte_d  = arg;
          tx_dc_d    = opcode[0];
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else if (arg == 8'h00) begin
          advance = 1'b1;
        end else begin
          cnt_d   = CNT_W'(arg) * DU_C;
          state_d = DELAY;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          advance    = 1'b1;
        end
      end
      DELAY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) advance = 1'b1;
      end
      FINISH: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Running off the top of the address space ends the sequence rather than wrapping.
    if (advance) begin
      if (addr_q == {ADDR_BITS{1'b1}}) begin
        state_d = FINISH;
      end else begin
        addr_d  = addr_q + ADDR_BITS'(1);
        state_d = FETCH;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign rom_address = addr_q;
  assign tx_valid    = tx_valid_q;
  assign tx_byte     = tx_byte_q;
  assign tx_dc       = tx_dc_q;

endmodule
